// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: each grantee keeps the grant for weight+1 accepted transfers.
// Latency: 1 cycle from request to registered grant; back-to-back bursts without a bubble.
// Backpressure: grant and burst credit are held unchanged while gnt_ready_i is low.
//
// Ports:
//   clk_i, rst_n_i  - rising-edge clock, asynchronous active-low reset
//   req_i           - per-requester request bits, held high while data is pending
//   weight_i        - packed per-requester weight, field i = [i*WGT_W +: WGT_W]
//   gnt_ready_i     - shared sink accepts the granted transfer this cycle
//   req_num_o       - index of the current grantee
//   req_num_val_o   - a grant is active
//   gnt_o           - one-hot grant, zero when no grant is active
//   burst_last_o    - the current transfer is the final one of the burst
module wrr_arb #(
    parameter int REQCNT = 16,
    parameter int WGT_W  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [REQCNT-1:0]         req_i,
    input  logic [REQCNT*WGT_W-1:0]   weight_i,
    input  logic                      gnt_ready_i,
    output logic [$clog2(REQCNT)-1:0] req_num_o,
    output logic                      req_num_val_o,
    output logic [REQCNT-1:0]         gnt_o,
    output logic                      burst_last_o
);

    localparam int IDX_W = $clog2(REQCNT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;        // search start: last released grantee + 1
    logic [WGT_W-1:0]   credit_q, credit_d;  // transfers remaining after the current one
    logic [IDX_W-1:0]   num_q, num_d;
    logic               val_q, val_d;
    logic [REQCNT-1:0]  gnt_q, gnt_d;
    logic               last_q, last_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic               cur_req;
    logic               rel_grant;   // current grantee gives up the grant this cycle
    logic               dec_credit;  // accepted transfer inside the burst
    logic               do_arb;      // a new arbitration result is taken this cycle
    logic [IDX_W-1:0]   arb_ptr;
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [WGT_W-1:0]   arb_wgt;

    // Index increment modulo REQCNT; REQCNT need not be a power of two.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(REQCNT - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // (base + off) modulo REQCNT with base < REQCNT and off < REQCNT,
    // so a single conditional subtraction is enough.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(REQCNT)) begin
            sum = sum - 32'(REQCNT);
        end
        return sum[IDX_W-1:0];
    endfunction

    // Decide whether the current grant is kept, decremented or released.
    // The rules are checked in priority order: withdrawal first, then stall,
    // then an accepted transfer.
    always_comb begin
        rel_grant  = 1'b0;
        dec_credit = 1'b0;
        cur_req    = req_i[num_q];

        if (state_q == ST_GRANT) begin
            if (!cur_req) begin
                rel_grant = 1'b1;
            end else if (gnt_ready_i) begin
                if (credit_q != '0) begin
                    dec_credit = 1'b1;
                end else begin
                    rel_grant = 1'b1;
                end
            end
        end

        // On a release the search starts just past the old grantee, so the
        // old grantee is considered last; a sole requester still wins again.
        arb_ptr = rel_grant ? idx_inc(num_q) : ptr_q;
        do_arb  = rel_grant | ((state_q == ST_IDLE) & (|req_i));
    end

    // Rotating first-set-bit search starting at arb_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < REQCNT; i++) begin
            if (!arb_found && req_i[idx_add(arb_ptr, unsigned'(i))]) begin
                arb_found = 1'b1;
                arb_idx   = idx_add(arb_ptr, unsigned'(i));
            end
        end
    end

    // Weight is only sampled at grant time; later changes wait for the next grant.
    assign arb_wgt = weight_i[arb_idx*WGT_W +: WGT_W];

    // ------------------------------------------------------------------
    // Next-state and registered-output computation
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        num_d    = num_q;

        if (rel_grant) begin
            ptr_d = arb_ptr;
        end

        if (dec_credit) begin
            credit_d = credit_q - WGT_W'(1);
        end

        if (do_arb) begin
            if (arb_found) begin
                state_d  = ST_GRANT;
                num_d    = arb_idx;
                credit_d = arb_wgt;
            end else begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        end

        val_d = (state_d == ST_GRANT);

        gnt_d = '0;
        if (val_d) begin
            gnt_d[num_d] = 1'b1;
        end

        last_d = val_d & (credit_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            num_q    <= '0;
            val_q    <= 1'b0;
            gnt_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            num_q    <= num_d;
            val_q    <= val_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
        end
    end

    assign req_num_o     = num_q;
    assign req_num_val_o = val_q;
    assign gnt_o         = gnt_q;
    assign burst_last_o  = last_q;

endmodule

// File: tb/tb_wrr_arb.sv
// Directed bench for wrr_arb (REQCNT=16, WGT_W=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each scenario task checks its own hand-computed expectations.
module tb_wrr_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] req = '0;
    logic [63:0] weight = '0;
    logic        ready = 1'b1;
    logic [3:0]  num;
    logic        val;
    logic [15:0] gnt;
    logic        last;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wrr_arb #(.REQCNT(16), .WGT_W(4)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_i         (req),
        .weight_i      (weight),
        .gnt_ready_i   (ready),
        .req_num_o     (num),
        .req_num_val_o (val),
        .gnt_o         (gnt),
        .burst_last_o  (last)
    );

    task automatic set_w(input int idx, input int w);
        weight[idx*4 +: 4] = 4'(w);
    endtask

    // Reset with all stimulus cleared; returns on a falling edge with reset released.
    task automatic apply_reset;
        rst_n  = 1'b0;
        req    = '0;
        ready  = 1'b1;
        weight = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (val !== 1'b0) begin n_err++; $display("FAIL rst_val: got %b want 0", val); end
        n_vec++; if (gnt !== 16'h0) begin n_err++; $display("FAIL rst_gnt: got %h want 0000", gnt); end
        n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", last); end
        n_vec++; if (num !== 4'd0) begin n_err++; $display("FAIL rst_num: got %0d want 0", num); end
        @(negedge clk);
        rst_n = 1'b1;
        // Traffic, then reset asserted between edges.
        set_w(5, 3);
        req = 16'h0020;
        @(negedge clk);
        n_vec++; if (val !== 1'b1) begin n_err++; $display("FAIL pre_rst_val: got %b want 1", val); end
        n_vec++; if (num !== 4'd5) begin n_err++; $display("FAIL pre_rst_num: got %0d want 5", num); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (val !== 1'b0) begin n_err++; $display("FAIL async_rst_val: got %b want 0", val); end
        n_vec++; if (gnt !== 16'h0) begin n_err++; $display("FAIL async_rst_gnt: got %h want 0000", gnt); end
        n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL async_rst_last: got %b want 0", last); end
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (val !== 1'b0) begin n_err++; $display("FAIL idle_val[%0d]: got %b want 0", i, val); end
            n_vec++; if (gnt !== 16'h0) begin n_err++; $display("FAIL idle_gnt[%0d]: got %h want 0000", i, gnt); end
            n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL idle_last[%0d]: got %b want 0", i, last); end
        end
    endtask

    task automatic test_sole_requester;
        apply_reset();
        set_w(3, 2);
        req = 16'h0008;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_vec++; if (val !== 1'b1) begin n_err++; $display("FAIL sole_val[%0d]: got %b want 1", i, val); end
            n_vec++; if (num !== 4'd3) begin n_err++; $display("FAIL sole_num[%0d]: got %0d want 3", i, num); end
            n_vec++; if (gnt !== 16'h0008) begin n_err++; $display("FAIL sole_gnt[%0d]: got %h want 0008", i, gnt); end
            n_vec++; if (last !== ((i % 3) == 2)) begin n_err++; $display("FAIL sole_last[%0d]: got %b want %b", i, last, ((i % 3) == 2)); end
        end
    endtask

    task automatic test_weighted_rotation;
        int exp_seq [10];
        bit exp_last [10];
        int wait_cnt;
        int max_wait;
        exp_seq  = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        exp_last = '{1, 1 - 1, 1, 0, 0, 1, 0, 0, 0, 1};
        wait_cnt = 0;
        max_wait = 0;
        apply_reset();
        set_w(0, 0);
        set_w(1, 1);
        set_w(2, 2);
        set_w(3, 3);
        req = 16'h000F;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++; if (val !== 1'b1) begin n_err++; $display("FAIL rot_val[%0d]: got %b want 1", i, val); end
            n_vec++; if (num !== 4'(exp_seq[i % 10])) begin n_err++; $display("FAIL rot_num[%0d]: got %0d want %0d", i, num, exp_seq[i % 10]); end
            n_vec++; if (last !== exp_last[i % 10]) begin n_err++; $display("FAIL rot_last[%0d]: got %b want %b", i, last, exp_last[i % 10]); end
            if (num == 4'd0) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
            end
        end
        n_vec++; if (max_wait != 9) begin n_err++; $display("FAIL rot_max_wait0: got %0d want 9", max_wait); end
    endtask

    task automatic test_backpressure;
        apply_reset();
        set_w(2, 2);
        set_w(3, 0);
        req = 16'h000C;
        @(negedge clk);
        n_vec++; if (num !== 4'd2 || last !== 1'b0) begin n_err++; $display("FAIL bp_first: got num=%0d last=%b want num=2 last=0", num, last); end
        @(negedge clk);
        n_vec++; if (num !== 4'd2 || last !== 1'b0) begin n_err++; $display("FAIL bp_credit1: got num=%0d last=%b want num=2 last=0", num, last); end
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (val !== 1'b1 || num !== 4'd2) begin n_err++; $display("FAIL bp_hold_num[%0d]: got val=%b num=%0d want val=1 num=2", i, val, num); end
            n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL bp_hold_credit[%0d]: got last=%b want 0", i, last); end
        end
        ready = 1'b1;
        @(negedge clk);
        n_vec++; if (num !== 4'd2 || last !== 1'b1) begin n_err++; $display("FAIL bp_final_xfer: got num=%0d last=%b want num=2 last=1", num, last); end
        @(negedge clk);
        n_vec++; if (num !== 4'd3 || gnt !== 16'h0008) begin n_err++; $display("FAIL bp_move_on: got num=%0d gnt=%h want num=3 gnt=0008", num, gnt); end
    endtask

    task automatic test_withdraw;
        apply_reset();
        set_w(0, 0);
        set_w(1, 3);
        set_w(2, 1);
        req = 16'h0002;
        @(negedge clk);
        n_vec++; if (num !== 4'd1 || val !== 1'b1) begin n_err++; $display("FAIL wd_grant1: got num=%0d val=%b want num=1 val=1", num, val); end
        req = 16'h0007;
        @(negedge clk);
        n_vec++; if (num !== 4'd1 || last !== 1'b0) begin n_err++; $display("FAIL wd_mid_burst: got num=%0d last=%b want num=1 last=0", num, last); end
        req = 16'h0005;
        @(negedge clk);
        n_vec++; if (num !== 4'd2) begin n_err++; $display("FAIL wd_next: got num=%0d want 2", num); end
        n_vec++; if (gnt !== 16'h0004) begin n_err++; $display("FAIL wd_gnt: got %h want 0004", gnt); end
        n_vec++; if (last !== 1'b0) begin n_err++; $display("FAIL wd_reload: got last=%b want 0", last); end
        @(negedge clk);
        n_vec++; if (num !== 4'd2 || last !== 1'b1) begin n_err++; $display("FAIL wd_burst_end: got num=%0d last=%b want num=2 last=1", num, last); end
        @(negedge clk);
        n_vec++; if (num !== 4'd0) begin n_err++; $display("FAIL wd_then0: got num=%0d want 0", num); end
    endtask

    task automatic test_wraparound;
        apply_reset();
        req = 16'h8000;
        @(negedge clk);
        n_vec++; if (num !== 4'd15 || last !== 1'b1) begin n_err++; $display("FAIL wrap_g15: got num=%0d last=%b want num=15 last=1", num, last); end
        req = 16'hC001;
        @(negedge clk);
        n_vec++; if (num !== 4'd0 || gnt !== 16'h0001) begin n_err++; $display("FAIL wrap_to0: got num=%0d gnt=%h want num=0 gnt=0001", num, gnt); end
        req = 16'h4001;
        @(negedge clk);
        n_vec++; if (num !== 4'd14 || gnt !== 16'h4000) begin n_err++; $display("FAIL wrap_to14: got num=%0d gnt=%h want num=14 gnt=4000", num, gnt); end
    endtask

    initial begin
        test_reset();
        test_sole_requester();
        test_weighted_rotation();
        test_backpressure();
        test_withdraw();
        test_wraparound();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
